// File: rtl/seven_segment_scan_ctrl_pkg.sv
// Shared encodings for the seven-segment scan controller: FSM states and pin polarities.
package seven_segment_scan_ctrl_pkg;

    typedef enum logic {
        GUARD_S = 1'b0,
        DRIVE_S = 1'b1
    } scan_state_t;

    // Common-anode board: anodes, segments and decimal point are all active-low.
    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic       ANODE_OFF = 1'b1;
    localparam logic       ANODE_ON  = 1'b0;
    localparam logic       DP_OFF    = 1'b1;

endpackage

// File: rtl/seven_segment_scan_ctrl_seven_segment.sv
// Hex nibble to active-low segment pattern, bit 6 = a ... bit 0 = g.
module seven_segment_scan_ctrl_seven_segment
    import seven_segment_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            4'hF: seg = 7'h38;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with guard blanking and frame-synchronous data update.
//   state   | meaning
//   GUARD_S | leading part of a digit slot, every anode off
//   DRIVE_S | anode of the current digit enabled
module seven_segment_scan_ctrl
    import seven_segment_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int GUARD      = 500
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Load_Valid,
    output logic                    Load_Ready,
    input  logic [4*NUM_DIGITS-1:0] Load_Data,
    input  logic [NUM_DIGITS-1:0]   Load_Dp,
    input  logic [NUM_DIGITS-1:0]   Blank_Mask,
    input  logic                    Lz_En,
    output logic [6:0]              Seg,
    output logic                    Dp,
    output logic [NUM_DIGITS-1:0]   Anode,
    output logic                    Frame_Done
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST      = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_GUARD_END = CW'(GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(NUM_DIGITS - 1);

    scan_state_t             state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic [NUM_DIGITS-1:0]   anode_nxt;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic                    cnt_last;
    logic                    frame_end;
    logic                    dark;
    logic                    blank_slot;
    logic                    upper_zero;

    assign cnt_last  = (cnt == CNT_LAST);
    assign frame_end = cnt_last && (idx == IDX_LAST);

    always_comb begin
        cur_nib   = 4'h0;
        anode_nxt = {NUM_DIGITS{ANODE_OFF}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = shadow_data[4*i +: 4];
                if (state == DRIVE_S)
                    anode_nxt[i] = ANODE_ON;
            end
        end
    end

    // Digit i is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_dark    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (shadow_data[4*i +: 4] == 4'h0);
            lz_dark[i] = Lz_En && upper_zero;
        end
    end

    assign dark       = Blank_Mask[idx] | lz_dark[idx];
    assign blank_slot = (state == GUARD_S) | dark;

    seven_segment_scan_ctrl_seven_segment u_dec (
        .hex (cur_nib),
        .seg (dec_seg)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= GUARD_S;
            cnt        <= '0;
            idx        <= '0;
            Anode      <= {NUM_DIGITS{ANODE_OFF}};
            Seg        <= SEG_OFF;
            Dp         <= DP_OFF;
            Frame_Done <= 1'b0;
        end else begin
            cnt <= cnt_last ? '0 : cnt + 1'b1;
            if (cnt_last)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            case (state)
                GUARD_S: if (cnt == CNT_GUARD_END) state <= DRIVE_S;
                DRIVE_S: if (cnt_last)             state <= GUARD_S;
            endcase
            // Segments are blanked during guard so they switch together with the anodes.
            Anode      <= anode_nxt;
            Seg        <= dec_seg | {7{blank_slot}};
            Dp         <= (blank_slot || !shadow_dp[idx]) ? DP_OFF : ~DP_OFF;
            Frame_Done <= frame_end;
        end
    end

    // Load_Ready low means the pending register holds an uncommitted frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Load_Ready  <= 1'b1;
            pend_data   <= '0;
            pend_dp     <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
        end else if (Load_Valid && Load_Ready) begin
            pend_data  <= Load_Data;
            pend_dp    <= Load_Dp;
            Load_Ready <= 1'b0;
        end else if (!Load_Ready && frame_end) begin
            shadow_data <= pend_data;
            shadow_dp   <= pend_dp;
            Load_Ready  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for the scan controller with NUM_DIGITS=4, PRESCALE=4, GUARD=1 (16-cycle frame).
module tb_seven_segment_scan_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Load_Valid = 1'b0;
    logic        Load_Ready;
    logic [15:0] Load_Data = 16'h0000;
    logic [3:0]  Load_Dp = 4'h0;
    logic [3:0]  Blank_Mask = 4'h0;
    logic        Lz_En = 1'b0;
    logic [6:0]  Seg;
    logic        Dp;
    logic [3:0]  Anode;
    logic        Frame_Done;

    int checks = 0;
    int errors = 0;
    int p = 0;   // clock edges since reset release; outputs sampled after edge p

    seven_segment_scan_ctrl #(
        .NUM_DIGITS (4),
        .PRESCALE   (4),
        .GUARD      (1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load_Valid (Load_Valid),
        .Load_Ready (Load_Ready),
        .Load_Data  (Load_Data),
        .Load_Dp    (Load_Dp),
        .Blank_Mask (Blank_Mask),
        .Lz_En      (Lz_En),
        .Seg        (Seg),
        .Dp         (Dp),
        .Anode      (Anode),
        .Frame_Done (Frame_Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) p <= Reset ? 0 : p + 1;

    // Output after edge ph reflects slot phase ph-1: cnt = (ph-1)%4, idx = ((ph-1)/4)%4.
    function automatic logic [3:0] exp_anode(int ph);
        logic [3:0] a;
        a = 4'b0001 << (((ph - 1) / 4) % 4);
        if ((ph - 1) % 4 == 0) return 4'hF;
        return ~a;
    endfunction

    function automatic logic [6:0] exp_seg(int ph, logic [27:0] segs);
        int i;
        i = ((ph - 1) / 4) % 4;
        if ((ph - 1) % 4 == 0) return 7'h7F;
        return segs[7*i +: 7];
    endfunction

    function automatic logic exp_dp(int ph, logic [3:0] dps);
        int i;
        i = ((ph - 1) / 4) % 4;
        if ((ph - 1) % 4 == 0) return 1'b1;
        return dps[i];
    endfunction

    always @(negedge Clk) begin
        if (p >= 1) begin
            checks++;
            if ($countones(~Anode) > 1 || (((p - 1) % 4 == 0) && Anode !== 4'hF)) begin
                errors++;
                $display("FAIL anode_guard p=%0d got=%h", p, Anode);
            end
            checks++;
            if (Frame_Done !== (((p % 16) == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL frame_done p=%0d got=%b exp=%b", p, Frame_Done, (p % 16) == 0);
            end
        end
    end

    task automatic wait_mod(input int m);
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while ((p % 16) != m && n < 64);
        checks++;
        if ((p % 16) != m) begin
            errors++;
            $display("FAIL wait_phase got=%0d exp=%0d", p % 16, m);
        end
    endtask

    task automatic load_frame(input logic [15:0] data, input logic [3:0] dpv);
        @(negedge Clk);
        Load_Valid = 1'b1;
        Load_Data  = data;
        Load_Dp    = dpv;
        @(negedge Clk);
        Load_Valid = 1'b0;
        wait_mod(0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        checks++;
        if (Anode !== 4'hF || Seg !== 7'h7F || Dp !== 1'b1 || Frame_Done !== 1'b0 || Load_Ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values anode=%h seg=%h dp=%b fd=%b rdy=%b", Anode, Seg, Dp, Frame_Done, Load_Ready);
        end
        Lz_En = 1'b1;
        Reset = 1'b0;
    endtask

    task automatic test_scan_idle();
        for (int k = 0; k < 32; k++) begin
            @(negedge Clk);
            checks++;
            if (Anode !== exp_anode(p) || Seg !== exp_seg(p, {7'h7F, 7'h7F, 7'h7F, 7'h01}) || Dp !== exp_dp(p, 4'hF)) begin
                errors++;
                $display("FAIL scan_idle p=%0d anode=%h seg=%h dp=%b", p, Anode, Seg, Dp);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        wait_mod(4);
        Load_Valid = 1'b1;
        Load_Data  = 16'h12AF;
        Load_Dp    = 4'h0;
        @(negedge Clk);
        Load_Valid = 1'b0;
        Load_Data  = 16'hFFFF;
        checks++;
        if (Load_Ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop got=%b exp=0", Load_Ready);
        end
        do begin
            @(negedge Clk);
            checks++;
            if (Anode !== exp_anode(p) || Seg !== exp_seg(p, {7'h7F, 7'h7F, 7'h7F, 7'h01}) || Dp !== exp_dp(p, 4'hF)) begin
                errors++;
                $display("FAIL load_hold p=%0d anode=%h seg=%h dp=%b", p, Anode, Seg, Dp);
            end
        end while ((p % 16) != 0);
        checks++;
        if (Load_Ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_return got=%b exp=1", Load_Ready);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            checks++;
            if (Anode !== exp_anode(p) || Seg !== exp_seg(p, {7'h4F, 7'h12, 7'h08, 7'h38}) || Dp !== exp_dp(p, 4'hF)) begin
                errors++;
                $display("FAIL load_show p=%0d anode=%h seg=%h dp=%b", p, Anode, Seg, Dp);
            end
        end
    endtask

    task automatic test_leading_zero();
        Lz_En = 1'b1;
        load_frame(16'h0040, 4'h0);
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            checks++;
            if (Seg !== exp_seg(p, {7'h7F, 7'h7F, 7'h4C, 7'h01}) || Dp !== exp_dp(p, 4'hF)) begin
                errors++;
                $display("FAIL lz_0040 p=%0d seg=%h dp=%b", p, Seg, Dp);
            end
        end
        Lz_En = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            checks++;
            if (Seg !== exp_seg(p, {7'h01, 7'h01, 7'h4C, 7'h01})) begin
                errors++;
                $display("FAIL lz_off p=%0d seg=%h", p, Seg);
            end
        end
        Lz_En = 1'b1;
        load_frame(16'h0000, 4'h0);
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            checks++;
            if (Anode !== exp_anode(p) || Seg !== exp_seg(p, {7'h7F, 7'h7F, 7'h7F, 7'h01})) begin
                errors++;
                $display("FAIL lz_0000 p=%0d anode=%h seg=%h", p, Anode, Seg);
            end
        end
    endtask

    task automatic test_blank_dp();
        Lz_En      = 1'b0;
        Blank_Mask = 4'b0100;
        load_frame(16'h1234, 4'b0100);
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            checks++;
            if (Anode !== exp_anode(p) || Seg !== exp_seg(p, {7'h4F, 7'h7F, 7'h06, 7'h4C}) || Dp !== exp_dp(p, 4'hF)) begin
                errors++;
                $display("FAIL blank_on p=%0d anode=%h seg=%h dp=%b", p, Anode, Seg, Dp);
            end
        end
        Blank_Mask = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            checks++;
            if (Seg !== exp_seg(p, {7'h4F, 7'h12, 7'h06, 7'h4C}) || Dp !== exp_dp(p, 4'b1011)) begin
                errors++;
                $display("FAIL blank_off p=%0d seg=%h dp=%b", p, Seg, Dp);
            end
        end
    endtask

    task automatic test_back_to_back();
        wait_mod(15);
        Load_Valid = 1'b1;
        Load_Data  = 16'h5678;
        Load_Dp    = 4'h0;
        @(negedge Clk);
        checks++;
        if (Load_Ready !== 1'b0) begin
            errors++;
            $display("FAIL edge_transfer got=%b exp=0", Load_Ready);
        end
        Load_Data = 16'h9999;
        Load_Dp   = 4'hF;
        for (int k = 1; k <= 16; k++) begin
            @(negedge Clk);
            checks++;
            if (Seg !== exp_seg(p, {7'h4F, 7'h12, 7'h06, 7'h4C}) || Dp !== exp_dp(p, 4'b1011)) begin
                errors++;
                $display("FAIL deferred_hold p=%0d seg=%h dp=%b", p, Seg, Dp);
            end
            if (k == 8) begin
                checks++;
                if (Load_Ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_busy got=%b exp=0", Load_Ready);
                end
            end
            if (k == 15) Load_Valid = 1'b0;
        end
        checks++;
        if (Load_Ready !== 1'b1) begin
            errors++;
            $display("FAIL deferred_commit got=%b exp=1", Load_Ready);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            checks++;
            if (Seg !== exp_seg(p, {7'h24, 7'h20, 7'h0F, 7'h00}) || Dp !== exp_dp(p, 4'hF)) begin
                errors++;
                $display("FAIL deferred_show p=%0d seg=%h dp=%b", p, Seg, Dp);
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        wait_mod(1);
        Load_Valid = 1'b1;
        Load_Data  = 16'hABCD;
        Load_Dp    = 4'hF;
        @(negedge Clk);
        Load_Valid = 1'b0;
        checks++;
        if (Load_Ready !== 1'b0) begin
            errors++;
            $display("FAIL pending_before_reset got=%b exp=0", Load_Ready);
        end
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (Anode !== 4'hF || Seg !== 7'h7F || Dp !== 1'b1 || Frame_Done !== 1'b0 || Load_Ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid anode=%h seg=%h dp=%b fd=%b rdy=%b", Anode, Seg, Dp, Frame_Done, Load_Ready);
        end
        Reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            checks++;
            if (Anode !== exp_anode(p) || Seg !== exp_seg(p, {7'h01, 7'h01, 7'h01, 7'h01}) || Dp !== exp_dp(p, 4'hF)) begin
                errors++;
                $display("FAIL after_reset p=%0d anode=%h seg=%h dp=%b", p, Anode, Seg, Dp);
            end
        end
        checks++;
        if (Load_Ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%b exp=1", Load_Ready);
        end
    endtask

    initial begin
        test_reset();
        test_scan_idle();
        test_load_mid_frame();
        test_leading_zero();
        test_blank_dp();
        test_back_to_back();
        test_reset_mid_drive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
